// File: rtl/condicionador_botoes_pkg.sv
// Shared constants, FSM encoding and helpers for the button conditioner.
package botoes_pkg;
  localparam int N_BOTOES = 7;
  localparam int COD_W    = 3;
  localparam logic [COD_W-1:0] CODIGO_NENHUM = 3'd0;

  typedef enum logic [1:0] {
    OCIOSO        = 2'd0,
    ATIVO         = 2'd1,
    ESPERA_SOLTAR = 2'd2
  } estado_t;

  // Index+1 of the highest set bit; callers only pass one-hot vectors.
  function automatic logic [COD_W-1:0] codifica(input logic [N_BOTOES-1:0] v);
    codifica = CODIGO_NENHUM;
    for (int i = 0; i < N_BOTOES; i++)
      if (v[i]) codifica = COD_W'(i + 1);
  endfunction

  function automatic logic [2:0] popcount(input logic [N_BOTOES-1:0] v);
    popcount = '0;
    for (int i = 0; i < N_BOTOES; i++)
      popcount = popcount + 3'(v[i]);
  endfunction
endpackage

// File: rtl/condicionador_botoes_if.sv
// Button-side and datapath-side signals of the conditioner.
interface condicionador_botoes_if;
  import botoes_pkg::*;
  logic [N_BOTOES-1:0] botoes_raw;
  logic                enable;
  logic [N_BOTOES-1:0] botoes;
  logic [COD_W-1:0]    codigo;
  logic                pulso_jogada;
  logic                pressionado;
  logic                multiplo;

  modport master (
    output botoes_raw, enable,
    input  botoes, codigo, pulso_jogada, pressionado, multiplo
  );
  modport slave (
    input  botoes_raw, enable,
    output botoes, codigo, pulso_jogada, pressionado, multiplo
  );
endinterface

// File: rtl/condicionador_botoes_debounce_bit.sv
// Two-flop synchroniser plus counter-based debouncer for one button.
module debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 10,
  parameter int CNT_W           = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic bruto_i,
  output logic estavel_o
);
  localparam logic [CNT_W-1:0] C_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sinc1_q, sinc_q, s_q, s_d;
  logic [CNT_W-1:0] c_q, c_d;

  // Any reversal back to the stable level restarts the count from zero.
  always_comb begin
    s_d = s_q;
    c_d = '0;
    if (sinc_q != s_q) begin
      if (c_q == C_MAX) s_d = sinc_q;
      else              c_d = c_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sinc1_q <= 1'b0;
      sinc_q  <= 1'b0;
      s_q     <= 1'b0;
      c_q     <= '0;
    end else begin
      sinc1_q <= bruto_i;
      sinc_q  <= sinc1_q;
      s_q     <= s_d;
      c_q     <= c_d;
    end
  end

  assign estavel_o = s_q;
endmodule

// File: rtl/condicionador_botoes.sv
// Debounces the note buttons and accepts single one-hot presses as clean pulses.
module condicionador_botoes
  import botoes_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 10,
  parameter int CNT_W           = 4
) (
  input logic                   clock,
  input logic                   reset,
  condicionador_botoes_if.slave bus
);
  logic [N_BOTOES-1:0] s;
  logic                one_hot;

  for (genvar i = 0; i < N_BOTOES; i++) begin : g_db
    debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db (
      .clock    (clock),
      .reset    (reset),
      .bruto_i  (bus.botoes_raw[i]),
      .estavel_o(s[i])
    );
  end

  assign one_hot = (s != '0) && ((s & (s - 1'b1)) == '0);

  estado_t             estado_q;
  logic [N_BOTOES-1:0] botoes_q;
  logic [COD_W-1:0]    codigo_q;
  logic                pulso_q, press_q, mult_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= OCIOSO;
      botoes_q <= '0;
      codigo_q <= CODIGO_NENHUM;
      pulso_q  <= 1'b0;
      press_q  <= 1'b0;
      mult_q   <= 1'b0;
    end else begin
      pulso_q <= 1'b0;
      press_q <= |s;
      mult_q  <= popcount(s) >= 3'd2;
      case (estado_q)
        OCIOSO: begin
          if (bus.enable && one_hot) begin
            estado_q <= ATIVO;
            botoes_q <= s;
            codigo_q <= codifica(s);
            pulso_q  <= 1'b1;
          end else if (s != '0) begin
            estado_q <= ESPERA_SOLTAR;
          end
        end
        ATIVO: begin
          // Release goes idle; anything else that disturbs the held press must be fully released first.
          if (s == '0) begin
            estado_q <= OCIOSO;
            botoes_q <= '0;
            codigo_q <= CODIGO_NENHUM;
          end else if (!bus.enable || s != botoes_q) begin
            estado_q <= ESPERA_SOLTAR;
            botoes_q <= '0;
            codigo_q <= CODIGO_NENHUM;
          end
        end
        ESPERA_SOLTAR: if (s == '0) estado_q <= OCIOSO;
        default:       estado_q <= OCIOSO;
      endcase
    end
  end

  assign bus.botoes       = botoes_q;
  assign bus.codigo       = codigo_q;
  assign bus.pulso_jogada = pulso_q;
  assign bus.pressionado  = press_q;
  assign bus.multiplo     = mult_q;
endmodule
